// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, byte indexing and serializer FSM encoding
//
// Purpose : common definitions for the AES state serializer and the row
//           permutation used by the full-width and column-serial rounds.
// Contents: AES_STATE_W / AES_COL_W widths, idx(r,c) byte index,
//           ST_IDLE / ST_SEND state encoding.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam int AES_ROWS    = 4;
  localparam int AES_COLS    = 4;

  typedef logic [AES_STATE_W-1:0] aes_state_t;
  typedef logic [AES_COL_W-1:0]   aes_col_t;
  typedef logic [1:0]             aes_col_idx_t;

  // Serializer FSM encoding, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Byte k of the state lives at bits [127-8k -: 8]; row r, col c is byte 4c+r.
  function automatic int idx(input int r, input int c);
    return 4 * c + r;
  endfunction

  // MSB position of state byte (r,c) in a 128-bit vector.
  function automatic int byte_msb(input int r, input int c);
    return AES_STATE_W - 1 - 8 * idx(r, c);
  endfunction

endpackage

// File: rtl/inv_shift_rows_ser_if.sv
// rtl/inv_shift_rows_ser_if.sv - state input and column output handshake bundle
//
// Purpose : groups the state-in handshake and the column-out handshake of
//           the serializer.
// Signals : in_valid/in_ready/data_in   - 128-bit state from the source
//           col_valid/col_ready/col_out - 32-bit column to the sink
//           col_idx/col_last            - column position side-band
// Modports: slave  - the serializer (consumes state, produces columns)
//           master - the environment (produces state, consumes columns)
interface inv_shift_rows_ser_if
  import aes_pkg::*;
();

  logic         in_valid;
  logic         in_ready;
  aes_state_t   data_in;
  logic         col_valid;
  logic         col_ready;
  aes_col_t     col_out;
  aes_col_idx_t col_idx;
  logic         col_last;

  modport slave (
    input  in_valid, data_in, col_ready,
    output in_ready, col_valid, col_out, col_idx, col_last
  );

  modport master (
    output in_valid, data_in, col_ready,
    input  in_ready, col_valid, col_out, col_idx, col_last
  );

endinterface

// File: rtl/inv_shift_rows_perm.sv
// rtl/inv_shift_rows_perm.sv - combinational AES (Inv)ShiftRows byte permutation
//
// Purpose : pure wiring permutation of a 128-bit AES state.
//           INVERSE=1: out[r][c] = in[r][(c-r) mod 4]
//           INVERSE=0: out[r][c] = in[r][(c+r) mod 4]
// Ports   : state_in  [127:0] in  - state before the permutation
//           state_out [127:0] out - state after the permutation
module inv_shift_rows_perm
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  aes_state_t state_in,
  output aes_state_t state_out
);

  for (genvar r = 0; r < AES_ROWS; r++) begin : g_row
    for (genvar c = 0; c < AES_COLS; c++) begin : g_col
      // Row 0 resolves to SRC_C == c, so it passes through unchanged.
      localparam int SRC_C = INVERSE ? ((c + AES_COLS - r) % AES_COLS)
                                     : ((c + r) % AES_COLS);
      assign state_out[byte_msb(r, c) -: 8] = state_in[byte_msb(r, SRC_C) -: 8];
    end
  end

endmodule

// File: rtl/inv_shift_rows_ser.sv
// rtl/inv_shift_rows_ser.sv - (Inv)ShiftRows a 128-bit state and emit it as four columns
//
// Purpose : captures a state through the row permutation into a register,
//           then streams it out one 32-bit column per accepted beat.
// Ports   : clk  in  - rising-edge clock
//           rst  in  - synchronous active-high reset
//           bus  if  - slave side of inv_shift_rows_ser_if
//                      (in_valid/in_ready/data_in, col_valid/col_ready/
//                       col_out/col_idx/col_last)
//           busy out - state register holds an unfinished state
module inv_shift_rows_ser
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_shift_rows_ser_if.slave  bus,
  output logic                 busy
);

  logic [0:0]   fsm_q;
  aes_state_t   state_q;
  aes_state_t   perm_state;
  aes_col_idx_t col_idx_q;
  aes_col_t     col_word;
  logic         send;
  logic         col_accept;
  logic         done;
  logic         in_accept;

  inv_shift_rows_perm #(
    .INVERSE (INVERSE)
  ) u_perm (
    .state_in  (bus.data_in),
    .state_out (perm_state)
  );

  assign send       = (fsm_q == ST_SEND);
  assign col_accept = send && bus.col_ready;
  assign done       = col_accept && (col_idx_q == 2'd3);

  // in_ready combinationally follows col_ready on the last column so a new
  // state can be captured in the same cycle the old one finishes (no bubble).
  assign bus.in_ready = !rst && (!send || done);
  assign in_accept    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      state_q   <= '0;
      col_idx_q <= '0;
    end else if (in_accept) begin
      // data_in is only sampled here, so X while in_valid=0 never reaches state_q.
      state_q   <= perm_state;
      col_idx_q <= '0;
      fsm_q     <= ST_SEND;
    end else if (done) begin
      fsm_q     <= ST_IDLE;
      col_idx_q <= '0;
    end else if (col_accept) begin
      col_idx_q <= col_idx_q + 2'd1;
    end
  end

  always_comb begin
    col_word = '0;
    case (col_idx_q)
      2'd0: col_word = state_q[127:96];
      2'd1: col_word = state_q[95:64];
      2'd2: col_word = state_q[63:32];
      2'd3: col_word = state_q[31:0];
      default: col_word = '0;
    endcase
  end

  // Outputs are zeroed outside SEND so stale columns are not presented in IDLE.
  assign bus.col_valid = send;
  assign bus.col_out   = send ? col_word : '0;
  assign bus.col_idx   = col_idx_q;
  assign bus.col_last  = send && (col_idx_q == 2'd3);
  assign busy          = send;

endmodule

// File: tb/tb_inv_shift_rows_ser.sv
// tb/tb_inv_shift_rows_ser.sv - directed and round-trip bench for inv_shift_rows_ser
module tb_inv_shift_rows_ser;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy_i;
  logic busy_f;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  inv_shift_rows_ser_if sb ();
  inv_shift_rows_ser_if fb ();

  inv_shift_rows_ser #(.INVERSE(1'b1)) u_inv (
    .clk  (clk),
    .rst  (rst),
    .bus  (sb.slave),
    .busy (busy_i)
  );

  inv_shift_rows_ser #(.INVERSE(1'b0)) u_fwd (
    .clk  (clk),
    .rst  (rst),
    .bus  (fb.slave),
    .busy (busy_f)
  );

  localparam logic [127:0] V1 = 128'h636b6776_f201ab7b_30d777c5_fe7c6f2b;
  localparam logic [127:0] E1 = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
  localparam logic [127:0] V2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] E2 = 128'h000d0a07_04010e0b_0805020f_0c090603;
  localparam logic [127:0] V3 = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
  localparam logic [127:0] E3 = 128'h636b6776_f201ab7b_30d777c5_fe7c6f2b;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string tag);
    #1;
    chk({tag, "_valid"}, 128'(sb.col_valid), 128'd0);
    chk({tag, "_busy"},  128'(busy_i),       128'd0);
    chk({tag, "_out"},   128'(sb.col_out),   128'd0);
    chk({tag, "_last"},  128'(sb.col_last),  128'd0);
  endtask

  task automatic load_inv(input string tag, input logic [127:0] v);
    sb.in_valid = 1'b1;
    sb.data_in  = v;
    #1;
    chk({tag, "_in_ready"}, 128'(sb.in_ready), 128'd1);
    tick();
    sb.in_valid = 1'b0;
    sb.data_in  = 'x;
  endtask

  // Drain one state from the inverse instance, column 0 first. Column
  // stall_col is held off for stall_len cycles. If nxt_en, the next state is
  // offered during column 3 and must be taken in that same cycle.
  task automatic drain_inv(input string tag, input logic [127:0] exp_state,
                           input int stall_col, input int stall_len,
                           input logic nxt_en, input logic [127:0] nxt);
    int nc = 0;
    int stalls = 0;
    int cycles = 0;
    logic [31:0] exp_col;
    for (int cyc = 0; cyc < 20 && nc < 4; cyc++) begin
      sb.col_ready = (nc == stall_col && stalls < stall_len) ? 1'b0 : 1'b1;
      if (nxt_en && nc == 3) begin
        sb.in_valid = 1'b1;
        sb.data_in  = nxt;
      end
      #1;
      exp_col = exp_state[127 - 32 * nc -: 32];
      chk({tag, "_valid"}, 128'(sb.col_valid), 128'd1);
      chk({tag, "_col"},   128'(sb.col_out),   128'(exp_col));
      chk({tag, "_idx"},   128'(sb.col_idx),   128'(nc));
      chk({tag, "_last"},  128'(sb.col_last),  128'(nc == 3));
      if (nc < 3 || !sb.col_ready)
        chk({tag, "_in_ready_lo"}, 128'(sb.in_ready), 128'd0);
      else if (nxt_en)
        chk({tag, "_in_ready_hi"}, 128'(sb.in_ready), 128'd1);
      if (sb.col_ready) nc++;
      else stalls++;
      cycles++;
      tick();
      sb.in_valid = 1'b0;
      sb.data_in  = 'x;
    end
    chk({tag, "_cycles"}, 128'(cycles), 128'(4 + stall_len));
    sb.col_ready = 1'b1;
  endtask

  task automatic get_cols(input logic fwd, output logic [127:0] s);
    int n = 0;
    s = '0;
    for (int cyc = 0; cyc < 8 && n < 4; cyc++) begin
      #1;
      if (!fwd && sb.col_valid) begin
        s[127 - 32 * sb.col_idx -: 32] = sb.col_out;
        n++;
      end else if (fwd && fb.col_valid) begin
        s[127 - 32 * fb.col_idx -: 32] = fb.col_out;
        n++;
      end
      tick();
    end
    chk(fwd ? "rt_fwd_cnt" : "rt_inv_cnt", 128'(n), 128'd4);
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] mid;
    logic [127:0] back;
    int fcnt;
    rst          = 1'b1;
    sb.in_valid  = 1'b0;
    sb.data_in   = '0;
    sb.col_ready = 1'b1;
    fb.in_valid  = 1'b0;
    fb.data_in   = '0;
    fb.col_ready = 1'b1;

    // Reset
    tick();
    tick();
    #1;
    chk("rst_in_ready", 128'(sb.in_ready), 128'd0);
    chk("rst_idx",      128'(sb.col_idx),  128'd0);
    check_idle("rst");
    rst = 1'b0;

    // Test 1: inverse, continuous col_ready
    load_inv("t1", V1);
    drain_inv("t1", E1, -1, 0, 1'b0, '0);
    check_idle("t1_end");
    chk("t1_end_in_ready", 128'(sb.in_ready), 128'd1);

    // col_ready with nothing valid changes nothing
    tick();
    tick();
    check_idle("idle_ready");

    // Test 2: forward instance
    fb.in_valid = 1'b1;
    fb.data_in  = V3;
    tick();
    fb.in_valid = 1'b0;
    fcnt = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t2_valid", 128'(fb.col_valid), 128'd1);
      chk("t2_col",   128'(fb.col_out),   128'(E3[127 - 32 * c -: 32]));
      chk("t2_idx",   128'(fb.col_idx),   128'(c));
      if (fb.col_valid) fcnt++;
      tick();
    end
    #1;
    chk("t2_cnt",     128'(fcnt),         128'd4);
    chk("t2_idle",    128'(fb.col_valid), 128'd0);
    chk("t2_busy",    128'(busy_f),       128'd0);

    // Test 3: backpressure, 3 stall cycles on column 1
    load_inv("t3", V1);
    drain_inv("t3", E1, 1, 3, 1'b0, '0);
    check_idle("t3_end");

    // Test 4: back-to-back, second state taken with column 3 of the first
    load_inv("t4a", V1);
    drain_inv("t4a", E1, -1, 0, 1'b1, V2);
    drain_inv("t4b", E2, -1, 0, 1'b0, '0);
    check_idle("t4_end");

    // Test 5: reset after column 1 is accepted
    load_inv("t5", V1);
    tick();
    tick();
    #1;
    chk("t5_pre_idx", 128'(sb.col_idx), 128'd2);
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", 128'(sb.in_ready), 128'd0);
    tick();
    check_idle("t5_rst");
    chk("t5_rst_idx", 128'(sb.col_idx), 128'd0);
    rst = 1'b0;
    load_inv("t5b", V2);
    drain_inv("t5b", E2, -1, 0, 1'b0, '0);

    // Test 6: inverse then forward round-trip
    for (int i = 0; i < 1000; i++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      sb.in_valid = 1'b1;
      sb.data_in  = v;
      tick();
      sb.in_valid = 1'b0;
      sb.data_in  = 'x;
      get_cols(1'b0, mid);
      fb.in_valid = 1'b1;
      fb.data_in  = mid;
      tick();
      fb.in_valid = 1'b0;
      get_cols(1'b1, back);
      chk("rt_equal", back, v);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
